mode_sequencer: RTL and testbench

- Top-level play-mode controller for the piano. Turns user switches and buttons into the `mode[2:0]` and `song_num[1:0]` selection that drives the output signal selector.
- Sequences the song player: start pulse, then a stop/acknowledge handshake before any mode or song change.
- Sits between the board I/O and the free-play, auto-play and learn-mode engines.

---
 rtl/mode_sequencer.sv | 172 +++++++++++++++++
 tb/tb_mode_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mode_sequencer.sv
// Play-mode controller: debounced buttons drive mode/song selection and the player start/stop handshake.
// Confirm pulse in cycle N -> LOAD in N+1 -> mode valid in N+2; mode/song changes wait for stop_ack or timeout.
module mode_sequencer #(
    parameter int DEB_CYCLES  = 2000000,
    parameter int NUM_SONGS   = 4,
    parameter int ACK_TIMEOUT = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] sw_mode,
    input  logic       btn_confirm,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       player_busy,
    input  logic       stop_ack,
    output logic [2:0] mode,
    output logic [1:0] song_num,
    output logic       play_start,
    output logic       play_stop,
    output logic       switching
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [1:0] LAST_SONG = 2'(NUM_SONGS - 1);

    localparam logic [2:0] M_IDLE  = 3'b000;
    localparam logic [2:0] M_FREE  = 3'b001;
    localparam logic [2:0] M_AUTO  = 3'b011;
    localparam logic [2:0] M_LEARN = 3'b111;

    typedef enum logic [1:0] {IDLE, ACTIVE, STOP_WAIT, LOAD} state_t;

    state_t         state, state_n;
    logic [2:0]     mode_n, target, target_n;
    logic [1:0]     song_n, song_inc, song_dec;
    logic [TW-1:0]  tcnt, tcnt_n;

    // Index 0 = confirm, 1 = next, 2 = prev.
    logic [2:0]     raw, sync1, sync2, stable, pulse;
    logic [DW-1:0]  deb_cnt [3];
    logic           ev_conf, ev_next, ev_prev;

    assign raw = {btn_prev, btn_next, btn_confirm};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            pulse  <= '0;
            for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                pulse[i] <= 1'b0;
                if (sync2[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
                    // Accepted after DEB_CYCLES consecutive samples of the new level.
                    stable[i]  <= sync2[i];
                    deb_cnt[i] <= '0;
                    pulse[i]   <= sync2[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    assign ev_conf = pulse[0];
    assign ev_next = pulse[1] & ~pulse[2] & ~ev_conf;
    assign ev_prev = pulse[2] & ~pulse[1] & ~ev_conf;

    assign song_inc = (song_num >= LAST_SONG) ? 2'd0 : song_num + 2'd1;
    assign song_dec = (song_num == 2'd0) ? LAST_SONG : song_num - 2'd1;

    function automatic logic is_play_mode(input logic [2:0] m);
        return (m == M_FREE) || (m == M_AUTO) || (m == M_LEARN);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mode     <= M_IDLE;
            song_num <= 2'd0;
            target   <= M_IDLE;
            tcnt     <= '0;
        end else begin
            state    <= state_n;
            mode     <= mode_n;
            song_num <= song_n;
            target   <= target_n;
            tcnt     <= tcnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        mode_n     = mode;
        song_n     = song_num;
        target_n   = target;
        tcnt_n     = '0;
        play_start = 1'b0;
        play_stop  = 1'b0;
        switching  = 1'b0;
        case (state)
            IDLE: begin
                if (ev_conf) begin
                    if (is_play_mode(sw_mode)) begin
                        target_n = sw_mode;
                        state_n  = LOAD;
                    end
                end else if (ev_next) begin
                    song_n = song_inc;
                end else if (ev_prev) begin
                    song_n = song_dec;
                end
            end
            LOAD: begin
                switching  = 1'b1;
                mode_n     = target;
                play_start = (target == M_AUTO) || (target == M_LEARN);
                state_n    = ACTIVE;
            end
            ACTIVE: begin
                if (ev_conf) begin
                    if (sw_mode == mode) begin
                        if (mode != M_FREE) begin
                            target_n = mode;
                            state_n  = STOP_WAIT;
                        end
                    end else if (is_play_mode(sw_mode) || sw_mode == M_IDLE) begin
                        target_n = sw_mode;
                        // Free play has no running player, so nothing to stop.
                        if (mode == M_FREE) begin
                            if (sw_mode == M_IDLE) begin
                                mode_n  = M_IDLE;
                                state_n = IDLE;
                            end else begin
                                state_n = LOAD;
                            end
                        end else begin
                            state_n = STOP_WAIT;
                        end
                    end
                end else if (ev_next || ev_prev) begin
                    song_n = ev_next ? song_inc : song_dec;
                    if (mode != M_FREE) begin
                        target_n = mode;
                        state_n  = player_busy ? STOP_WAIT : LOAD;
                    end
                end
            end
            STOP_WAIT: begin
                play_stop = 1'b1;
                switching = 1'b1;
                if (stop_ack || tcnt == TW'(ACK_TIMEOUT - 1)) begin
                    if (target != M_IDLE) begin
                        state_n = LOAD;
                    end else begin
                        mode_n  = M_IDLE;
                        state_n = IDLE;
                    end
                end else begin
                    tcnt_n = tcnt + TW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mode_sequencer.sv
// Scenario bench for mode_sequencer: expected started songs are queued at stimulus time and matched against observed play_start events.
module tb_mode_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] sw_mode = 3'b000;
    logic       btn_confirm = 1'b0, btn_next = 1'b0, btn_prev = 1'b0;
    logic       player_busy = 1'b0, stop_ack = 1'b0;
    logic [2:0] mode;
    logic [1:0] song_num;
    logic       play_start, play_stop, switching;

    mode_sequencer #(.DEB_CYCLES(4), .NUM_SONGS(4), .ACK_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .sw_mode(sw_mode), .btn_confirm(btn_confirm),
        .btn_next(btn_next), .btn_prev(btn_prev), .player_busy(player_busy),
        .stop_ack(stop_ack), .mode(mode), .song_num(song_num),
        .play_start(play_start), .play_stop(play_stop), .switching(switching)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int errs = 0;
    int n_start, n_stop, n_both;
    bit auto_ack = 1'b0;
    logic [1:0] exp_q[$];
    logic [1:0] obs_q[$];

    // One clock step; samples outputs 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (play_start) begin
            n_start++;
            obs_q.push_back(song_num);
        end
        if (play_stop) n_stop++;
        if (play_start && play_stop) n_both++;
        stop_ack = auto_ack && play_stop;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic clr_mon();
        n_start = 0;
        n_stop  = 0;
    endtask

    task automatic press(input int idx, input int hold);
        if (idx == 0) btn_confirm = 1'b1;
        if (idx == 1) btn_next = 1'b1;
        if (idx == 2) btn_prev = 1'b1;
        run(hold);
        btn_confirm = 1'b0;
        btn_next = 1'b0;
        btn_prev = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        vec++; if (mode !== 3'b000) begin errs++; $display("FAIL reset_mode got %b want 000", mode); end
        vec++; if (song_num !== 2'd0) begin errs++; $display("FAIL reset_song got %0d want 0", song_num); end
        vec++; if (play_start !== 1'b0) begin errs++; $display("FAIL reset_start got %b want 0", play_start); end
        vec++; if (play_stop !== 1'b0) begin errs++; $display("FAIL reset_stop got %b want 0", play_stop); end
        vec++; if (switching !== 1'b0) begin errs++; $display("FAIL reset_switching got %b want 0", switching); end
        run(3);
        rst = 1'b0;
        n_both = 0;
        run(3);
    endtask

    task automatic test_confirm_auto();
        bit seen = 0;
        logic [2:0] pm = 3'bx, nm = 3'bx;
        logic ps = 1'bx;
        sw_mode = 3'b011;
        clr_mon();
        exp_q.push_back(2'd0);
        btn_confirm = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (i == 9) btn_confirm = 1'b0;
            if (play_start && !seen) begin
                seen = 1;
                pm = mode;
                ps = switching;
                tick();
                nm = mode;
            end
        end
        btn_confirm = 1'b0;
        vec++; if (seen !== 1'b1) begin errs++; $display("FAIL confirm_start_seen got %b want 1", seen); end
        vec++; if (pm !== 3'b000) begin errs++; $display("FAIL confirm_mode_in_load got %b want 000", pm); end
        vec++; if (ps !== 1'b1) begin errs++; $display("FAIL confirm_switching_in_load got %b want 1", ps); end
        vec++; if (nm !== 3'b011) begin errs++; $display("FAIL confirm_mode_after_load got %b want 011", nm); end
        vec++; if (n_start !== 1) begin errs++; $display("FAIL confirm_start_count got %0d want 1", n_start); end
        vec++; if (song_num !== 2'd0) begin errs++; $display("FAIL confirm_song got %0d want 0", song_num); end
        vec++;
        if (obs_q.size() == 0) begin errs++; $display("FAIL confirm_sb got no start want song %0d", exp_q[0]); exp_q.delete(); end
        else if (obs_q[0] !== exp_q[0]) begin errs++; $display("FAIL confirm_sb got %0d want %0d", obs_q[0], exp_q[0]); end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_next_wrap();
        int btn [5] = '{1, 1, 1, 1, 2};
        logic [1:0] want [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd3};
        player_busy = 1'b1;
        auto_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            clr_mon();
            exp_q.push_back(want[k]);
            press(btn[k], 8);
            run(12);
            vec++; if (n_start !== 1) begin errs++; $display("FAIL next%0d_start_count got %0d want 1", k, n_start); end
            vec++; if (n_stop < 1) begin errs++; $display("FAIL next%0d_stop_seen got %0d want >=1", k, n_stop); end
            vec++; if (song_num !== want[k]) begin errs++; $display("FAIL next%0d_song got %0d want %0d", k, song_num, want[k]); end
            vec++;
            if (obs_q.size() == 0) begin errs++; $display("FAIL next%0d_sb got no start want song %0d", k, want[k]); void'(exp_q.pop_front()); end
            else begin
                if (obs_q[0] !== exp_q[0]) begin errs++; $display("FAIL next%0d_sb got %0d want %0d", k, obs_q[0], exp_q[0]); end
                void'(obs_q.pop_front());
                void'(exp_q.pop_front());
            end
            obs_q.delete();
        end
        vec++; if (mode !== 3'b011) begin errs++; $display("FAIL next_mode_kept got %b want 011", mode); end
    endtask

    task automatic test_timeout();
        auto_ack = 1'b0;
        sw_mode = 3'b001;
        clr_mon();
        press(0, 8);
        run(30);
        vec++; if (n_stop !== 16) begin errs++; $display("FAIL timeout_stop_cycles got %0d want 16", n_stop); end
        vec++; if (n_start !== 0) begin errs++; $display("FAIL timeout_start_count got %0d want 0", n_start); end
        vec++; if (mode !== 3'b001) begin errs++; $display("FAIL timeout_mode got %b want 001", mode); end
        vec++; if (switching !== 1'b0) begin errs++; $display("FAIL timeout_switching got %b want 0", switching); end
        obs_q.delete();
    endtask

    task automatic test_glitch();
        sw_mode = 3'b111;
        clr_mon();
        press(0, 2);
        run(8);
        press(0, 1);
        run(1);
        press(0, 1);
        run(1);
        press(0, 1);
        run(10);
        vec++; if (mode !== 3'b001) begin errs++; $display("FAIL glitch_mode got %b want 001", mode); end
        vec++; if (n_start !== 0) begin errs++; $display("FAIL glitch_start_count got %0d want 0", n_start); end
        exp_q.push_back(song_num);
        press(0, 12);
        run(12);
        vec++; if (n_start !== 1) begin errs++; $display("FAIL held_start_count got %0d want 1", n_start); end
        vec++; if (mode !== 3'b111) begin errs++; $display("FAIL held_mode got %b want 111", mode); end
        vec++;
        if (obs_q.size() == 0) begin errs++; $display("FAIL held_sb got no start want song %0d", exp_q[0]); end
        else if (obs_q[0] !== exp_q[0]) begin errs++; $display("FAIL held_sb got %0d want %0d", obs_q[0], exp_q[0]); end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_active_confirms();
        auto_ack = 1'b1;
        sw_mode = 3'b010;
        clr_mon();
        press(0, 8);
        run(12);
        vec++; if (n_start + n_stop !== 0) begin errs++; $display("FAIL invalid_code_activity got %0d want 0", n_start + n_stop); end
        vec++; if (mode !== 3'b111) begin errs++; $display("FAIL invalid_code_mode got %b want 111", mode); end
        sw_mode = 3'b111;
        clr_mon();
        exp_q.push_back(song_num);
        press(0, 8);
        run(12);
        vec++; if (n_stop < 1 || n_start !== 1) begin errs++; $display("FAIL restart_handshake got stop=%0d start=%0d want stop>=1 start=1", n_stop, n_start); end
        vec++;
        if (obs_q.size() == 0) begin errs++; $display("FAIL restart_sb got no start want song %0d", exp_q[0]); end
        else if (obs_q[0] !== exp_q[0]) begin errs++; $display("FAIL restart_sb got %0d want %0d", obs_q[0], exp_q[0]); end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [1:0] s0;
        sw_mode = 3'b000;
        clr_mon();
        press(0, 8);
        run(12);
        vec++; if (mode !== 3'b000) begin errs++; $display("FAIL to_idle_mode got %b want 000", mode); end
        vec++; if (n_start !== 0) begin errs++; $display("FAIL to_idle_start got %0d want 0", n_start); end
        s0 = song_num;
        sw_mode = 3'b111;
        clr_mon();
        exp_q.push_back(s0);
        btn_next = 1'b1;
        press(0, 8);
        run(12);
        vec++; if (mode !== 3'b111) begin errs++; $display("FAIL same_cycle_mode got %b want 111", mode); end
        vec++; if (song_num !== s0) begin errs++; $display("FAIL same_cycle_song got %0d want %0d", song_num, s0); end
        vec++;
        if (obs_q.size() == 0) begin errs++; $display("FAIL same_cycle_sb got no start want song %0d", exp_q[0]); end
        else if (obs_q[0] !== exp_q[0]) begin errs++; $display("FAIL same_cycle_sb got %0d want %0d", obs_q[0], exp_q[0]); end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_in_stop();
        bit seen = 0;
        auto_ack = 1'b0;
        player_busy = 1'b1;
        sw_mode = 3'b011;
        btn_confirm = 1'b1;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            if (i == 9) btn_confirm = 1'b0;
            if (play_stop) seen = 1;
        end
        btn_confirm = 1'b0;
        vec++; if (seen !== 1'b1) begin errs++; $display("FAIL rst_stop_entered got %b want 1", seen); end
        rst = 1'b1;
        #1;
        vec++; if (play_stop !== 1'b0) begin errs++; $display("FAIL rst_stop_level got %b want 0", play_stop); end
        vec++; if (mode !== 3'b000) begin errs++; $display("FAIL rst_stop_mode got %b want 000", mode); end
        vec++; if (switching !== 1'b0) begin errs++; $display("FAIL rst_stop_switching got %b want 0", switching); end
        run(3);
        rst = 1'b0;
        clr_mon();
        run(30);
        vec++; if (n_start + n_stop !== 0) begin errs++; $display("FAIL rst_after_activity got %0d want 0", n_start + n_stop); end
        vec++; if (mode !== 3'b000) begin errs++; $display("FAIL rst_after_mode got %b want 000", mode); end
    endtask

    initial begin
        test_reset();
        test_confirm_auto();
        test_next_wrap();
        test_timeout();
        test_glitch();
        test_active_confirms();
        test_back_to_back();
        test_reset_in_stop();
        vec++; if (n_both !== 0) begin errs++; $display("FAIL start_stop_overlap got %0d want 0", n_both); end
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
